// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcodes, ALU operation codes and the datapath control bundle.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_ADDIEX = 4'd8,
      S_ADDIWB = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       branch_bne;
      logic       jump;
      logic [1:0] alu_op;
      logic       pc_write;
      logic       ir_write;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // State reached from DECODE; FETCH marks an opcode this unit does not implement.
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW:   return S_MEMADR;
         OP_RTYPE:       return S_EXEC;
         OP_ADDI:        return S_ADDIEX;
         OP_BEQ, OP_BNE: return S_BRANCH;
         OP_J:           return S_JUMP;
         default:        return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decode: maps the registered state and the opcode latched in
// DECODE onto the datapath control bundle.
module mc_outdec
   import mc_pkg::*;
(
   input  logic [3:0]        state,
   input  logic [5:0]        op,
   output logic [CTRL_W-1:0] ctrl
);

   ctrl_t c;

   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
      c = '0;
      case (state_t'(state))
         S_FETCH: begin
            c.ir_write = 1'b1;
            c.pc_write = 1'b1;
            c.alu_op   = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            c.alu_src = 1'b1;
            c.alu_op  = ALU_ADD;
         end
         S_MEMRD:  c.mem_read  = 1'b1;
         S_MEMWR:  c.mem_write = 1'b1;
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_EXEC:   c.alu_op = ALU_FUNCT;
         S_ALUWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_ADDIWB: c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_op     = ALU_SUB;
            c.branch     = (op == OP_BEQ);
            c.branch_bne = (op == OP_BNE);
         end
         S_JUMP:   c.jump = 1'b1;
         default:  c = '0;
      endcase
   end

   assign ctrl = c;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM with a bounded memory-wait counter;
// output decoding lives in mc_outdec.
module mc_control
   import mc_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic       mem_ready,
   output logic       RegDst,
   output logic       AluSrc,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Branch,
   output logic       Branch_bne,
   output logic       Jump,
   output logic [1:0] ALUOp,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      st;
   logic [5:0]  op_q;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;
   logic        illegal_q;
   logic        mem_err_q;
   logic [CTRL_W-1:0] ctrl_raw;
   ctrl_t       c;

   assign wait_nxt = wait_cnt + 8'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= S_FETCH;
         op_q      <= '0;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
         case (st)
            S_FETCH:  st <= S_DECODE;
            S_DECODE: begin
               op_q      <= OpCode;
               st        <= decode_next(OpCode);
               illegal_q <= (decode_next(OpCode) == S_FETCH);
            end
            S_MEMADR: begin
               wait_cnt <= '0;
               st       <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
               if (mem_ready) begin
                  st <= (st == S_MEMRD) ? S_MEMWB : S_FETCH;
               end else begin
                  wait_cnt <= wait_nxt;
                  // Give up on a stalled access: no write-back, flag the error.
                  if (wait_nxt == TIMEOUT_CNT) begin
                     st        <= S_FETCH;
                     mem_err_q <= 1'b1;
                  end
               end
            end
            S_EXEC:   st <= S_ALUWB;
            S_ADDIEX: st <= S_ADDIWB;
            default:  st <= S_FETCH;
         endcase
      end
   end

   mc_outdec u_outdec (
      .state (st),
      .op    (op_q),
      .ctrl  (ctrl_raw)
   );

   // FETCH decodes to active enables, so reset must also mask the decoded bundle.
   assign c = ctrl_t'(ctrl_raw & {CTRL_W{reset}});

   assign RegDst     = c.reg_dst;
   assign AluSrc     = c.alu_src;
   assign MemtoReg   = c.mem_to_reg;
   assign RegWrite   = c.reg_write;
   assign MemRead    = c.mem_read;
   assign MemWrite   = c.mem_write;
   assign Branch     = c.branch;
   assign Branch_bne = c.branch_bne;
   assign Jump       = c.jump;
   assign ALUOp      = c.alu_op;
   assign PCWrite    = c.pc_write;
   assign IRWrite    = c.ir_write;
   assign illegal_op = illegal_q;
   assign mem_err    = mem_err_q;
   assign state      = st;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class cycle by cycle
// against hand-derived state and control expectations.
module tb_mc_control;
   import mc_pkg::*;

   logic       clk;
   logic       reset;
   logic [5:0] OpCode;
   logic       mem_ready;
   logic       RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite;
   logic       Branch, Branch_bne, Jump, PCWrite, IRWrite, illegal_op, mem_err;
   logic [1:0] ALUOp;
   logic [3:0] state;
   logic [14:0] outs;

   int errors = 0;
   int checks = 0;

   // Bit order: RegDst AluSrc MemtoReg RegWrite MemRead MemWrite Branch Branch_bne Jump | ALUOp | PCWrite IRWrite | illegal_op mem_err
   localparam logic [14:0] E_ZERO   = 15'b000000000_00_00_00;
   localparam logic [14:0] E_FETCH  = 15'b000000000_00_11_00;
   localparam logic [14:0] E_F_ILL  = 15'b000000000_00_11_10;
   localparam logic [14:0] E_F_MERR = 15'b000000000_00_11_01;
   localparam logic [14:0] E_ADRIMM = 15'b010000000_00_00_00;
   localparam logic [14:0] E_MEMRD  = 15'b000010000_00_00_00;
   localparam logic [14:0] E_MEMWB  = 15'b001100000_00_00_00;
   localparam logic [14:0] E_MEMWR  = 15'b000001000_00_00_00;
   localparam logic [14:0] E_EXEC   = 15'b000000000_10_00_00;
   localparam logic [14:0] E_ALUWB  = 15'b100100000_00_00_00;
   localparam logic [14:0] E_ADDIWB = 15'b000100000_00_00_00;
   localparam logic [14:0] E_BEQ    = 15'b000000100_01_00_00;
   localparam logic [14:0] E_BNE    = 15'b000000010_01_00_00;
   localparam logic [14:0] E_JUMP   = 15'b000000001_00_00_00;

   assign outs = {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                  Branch, Branch_bne, Jump, ALUOp, PCWrite, IRWrite,
                  illegal_op, mem_err};

   mc_control #(.TIMEOUT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .OpCode     (OpCode),
      .mem_ready  (mem_ready),
      .RegDst     (RegDst),
      .AluSrc     (AluSrc),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Branch     (Branch),
      .Branch_bne (Branch_bne),
      .Jump       (Jump),
      .ALUOp      (ALUOp),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .illegal_op (illegal_op),
      .mem_err    (mem_err),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Check the current cycle, then step to just after the next rising edge.
   task automatic expect_cycle(input string tag, input state_t st, input logic [14:0] o);
      check({tag, "_st"}, 16'(state), 16'(st));
      check({tag, "_out"}, 16'(outs), 16'(o));
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      OpCode    = OP_RTYPE;
      mem_ready = 1'b0;
      #1;
      check("rst_st", 16'(state), 16'(S_FETCH));
      check("rst_out", 16'(outs), 16'(E_ZERO));
      @(posedge clk);
      #1;
      check("rst_hold_out", 16'(outs), 16'(E_ZERO));
      @(negedge clk);
      reset = 1'b1;
      #1;

      // R-type: 4 cycles, write only in ALUWB
      expect_cycle("r_fetch", S_FETCH, E_FETCH);
      expect_cycle("r_dec", S_DECODE, E_ZERO);
      expect_cycle("r_exec", S_EXEC, E_EXEC);
      expect_cycle("r_wb", S_ALUWB, E_ALUWB);

      // lw with three wait cycles: 8 cycles total
      OpCode = OP_LW;
      expect_cycle("lw_fetch", S_FETCH, E_FETCH);
      expect_cycle("lw_dec", S_DECODE, E_ZERO);
      expect_cycle("lw_adr", S_MEMADR, E_ADRIMM);
      OpCode = OP_RTYPE;
      for (int i = 0; i < 3; i++) expect_cycle("lw_wait", S_MEMRD, E_MEMRD);
      mem_ready = 1'b1;
      expect_cycle("lw_rdy", S_MEMRD, E_MEMRD);
      mem_ready = 1'b0;
      expect_cycle("lw_wb", S_MEMWB, E_MEMWB);

      // bne, with OpCode switched to beq after DECODE
      OpCode = OP_BNE;
      expect_cycle("bne_fetch", S_FETCH, E_FETCH);
      expect_cycle("bne_dec", S_DECODE, E_ZERO);
      OpCode = OP_BEQ;
      expect_cycle("bne_br", S_BRANCH, E_BNE);

      // beq
      expect_cycle("beq_fetch", S_FETCH, E_FETCH);
      expect_cycle("beq_dec", S_DECODE, E_ZERO);
      expect_cycle("beq_br", S_BRANCH, E_BEQ);

      // illegal opcode: 2 cycles, pulse seen in the following FETCH
      OpCode = 6'b111111;
      expect_cycle("ill_fetch", S_FETCH, E_FETCH);
      expect_cycle("ill_dec", S_DECODE, E_ZERO);
      OpCode = OP_J;
      expect_cycle("ill_pulse", S_FETCH, E_F_ILL);

      // j, mem_ready high throughout must be ignored
      mem_ready = 1'b1;
      expect_cycle("j_dec", S_DECODE, E_ZERO);
      expect_cycle("j_jump", S_JUMP, E_JUMP);

      // addi
      OpCode = OP_ADDI;
      expect_cycle("addi_fetch", S_FETCH, E_FETCH);
      expect_cycle("addi_dec", S_DECODE, E_ZERO);
      expect_cycle("addi_ex", S_ADDIEX, E_ADRIMM);
      expect_cycle("addi_wb", S_ADDIWB, E_ADDIWB);

      // sw ready on first wait cycle: 4 cycles
      OpCode = OP_SW;
      expect_cycle("sw_fetch", S_FETCH, E_FETCH);
      expect_cycle("sw_dec", S_DECODE, E_ZERO);
      expect_cycle("sw_adr", S_MEMADR, E_ADRIMM);
      expect_cycle("sw_wr", S_MEMWR, E_MEMWR);

      // sw timeout: 15 wait cycles then FETCH with mem_err
      mem_ready = 1'b0;
      expect_cycle("swto_fetch", S_FETCH, E_FETCH);
      expect_cycle("swto_dec", S_DECODE, E_ZERO);
      expect_cycle("swto_adr", S_MEMADR, E_ADRIMM);
      for (int i = 0; i < 15; i++) expect_cycle("swto_wait", S_MEMWR, E_MEMWR);
      OpCode = OP_LW;
      expect_cycle("swto_err", S_FETCH, E_F_MERR);
      expect_cycle("swto_next", S_DECODE, E_ZERO);

      // lw interrupted by reset mid-MEMRD
      expect_cycle("lwr_adr", S_MEMADR, E_ADRIMM);
      expect_cycle("lwr_wait", S_MEMRD, E_MEMRD);
      #2;
      reset = 1'b0;
      #1;
      check("lwr_async_st", 16'(state), 16'(S_FETCH));
      check("lwr_async_out", 16'(outs), 16'(E_ZERO));
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      check("lwr_hold_out", 16'(outs), 16'(E_ZERO));
      @(negedge clk);
      reset  = 1'b1;
      OpCode = OP_RTYPE;
      #1;
      expect_cycle("lwr_fetch", S_FETCH, E_FETCH);
      expect_cycle("lwr_dec", S_DECODE, E_ZERO);
      expect_cycle("lwr_exec", S_EXEC, E_EXEC);
      expect_cycle("lwr_wb", S_ALUWB, E_ALUWB);
      check("lwr_back", 16'(state), 16'(S_FETCH));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles waiting on mem_ready before abort (range 1..255).
REQ-002 Port: clk  input  1  single system clock, all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: OpCode  input  6  instruction opcode from datapath (Instruction[31:26]).
REQ-005 Port: mem_ready  input  1  data-memory access complete, sampled in MEMRD/MEMWR.
REQ-006 Ports: RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Branch_bne, Jump  output  1 each  datapath controls, same meaning as datapath inputs.
REQ-007 Port: ALUOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-008 Ports: PCWrite, IRWrite  output  1 each  PC update enable; instruction-register load enable.
REQ-009 Ports: illegal_op, mem_err  output  1 each  one-cycle error pulses.
REQ-010 Port: state  output  4  current state encoding, for debug.

Function
REQ-011 SHALL be a Moore FSM; all outputs SHALL be decoded from registered state only (mem_ready/OpCode never combinationally reach outputs, except as noted in REQ-020).
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
REQ-013 FETCH: IRWrite=1, PCWrite=1, ALUOp=00; next DECODE.
REQ-014 DECODE by OpCode: 100011/101011 -> MEMADR; 000000 -> EXEC; 001000 -> ADDIEX; 000100/000101 -> BRANCH; 000010 -> JUMP; other -> FETCH with illegal_op=1 for one cycle.
REQ-015 MEMADR: AluSrc=1, ALUOp=00; next MEMRD (lw) or MEMWR (sw), from the opcode latched in DECODE.
REQ-016 MEMRD: MemRead=1 held until mem_ready=1, then MEMWB; MEMWR: MemWrite=1 held until mem_ready=1, then FETCH.
REQ-017 MEMWB: MemtoReg=1, RegWrite=1, RegDst=0; next FETCH.
REQ-018 EXEC: ALUOp=10, AluSrc=0 -> ALUWB: RegDst=1, RegWrite=1 -> FETCH.
REQ-019 ADDIEX: AluSrc=1, ALUOp=00 -> ADDIWB: RegDst=0, RegWrite=1 -> FETCH.
REQ-020 BRANCH: ALUOp=01, Branch=1 for 000100, Branch_bne=1 for 000101 (latched opcode), PCWrite=0 -> FETCH; JUMP: Jump=1 -> FETCH.
REQ-021 Cycle counts: R-type 4, addi 4, sw 4+waits, lw 5+waits, beq/bne 3, j 3, illegal 2.
REQ-022 Wait counter: 8-bit, cleared on MEMRD/MEMWR entry, +1 per cycle mem_ready=0; reaching TIMEOUT -> FETCH, mem_err=1 one cycle, no MEMWB write.
REQ-023 mem_ready=1 on first wait-state cycle SHALL give zero added wait cycles; mem_ready outside MEMRD/MEMWR SHALL be ignored.
REQ-024 OpCode SHALL be latched into an internal register in DECODE; changes later in the instruction SHALL be ignored.
REQ-025 All outputs not named active for a state SHALL be 0.

Reset
REQ-026 reset=0 SHALL immediately force state FETCH, clear wait counter and latched opcode, and drive every output 0 (including IRWrite/PCWrite) while asserted.
REQ-027 Reset mid-instruction (including during memory wait) SHALL abandon it with no RegWrite/MemWrite pulse; first edge after release performs FETCH.

Structure
REQ-028 State encodings, opcode constants and ALUOp codes SHALL reside in shared package mc_pkg.
REQ-029 Output decode SHALL be one sub-module mc_outdec (state + latched opcode -> controls); the FSM and counter stay in mc_control.

Verification
REQ-030 OpCode=000000 after reset -> states FETCH,DECODE,EXEC,ALUWB,FETCH; RegWrite=1 and RegDst=1 only in ALUWB.
REQ-031 OpCode=100011, mem_ready low 3 cycles then high -> MemRead high 4 cycles, MEMWB MemtoReg=1 RegWrite=1, total 8 cycles.
REQ-032 OpCode=000101 -> Branch_bne=1, Branch=0, ALUOp=01 in BRANCH; 3 cycles total.
REQ-033 OpCode=111111 -> illegal_op pulse 1 cycle, back to FETCH after 2 cycles, no write enables.
REQ-034 OpCode=101011, mem_ready held 0, TIMEOUT=15 -> mem_err pulse after 15 wait cycles, FETCH next, MemWrite drops.
REQ-035 reset=0 asserted mid-MEMRD -> all outputs 0 asynchronously, FETCH after release, no MEMWB.
